// File: rtl/wbus_if.sv
// WBUS connection bundle between the bus sources/consumers and the arbiter.
interface wbus_if #(
  parameter int unsigned N_SRC = 9,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 8
);
  logic [N_SRC-1:0]    req;
  logic [N_SRC-1:0]    lock;
  logic [N_SRC*DW-1:0] src_data;
  logic                clr_stat;
  logic [N_SRC-1:0]    grant;
  logic [DW-1:0]       bus_out;
  logic                bus_valid;
  logic [CNT_W-1:0]    conflict_cnt;

  // Source side: raises requests and data, observes the driven bus.
  modport master (
    output req, lock, src_data, clr_stat,
    input  grant, bus_out, bus_valid, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, lock, src_data, clr_stat,
    output grant, bus_out, bus_valid, conflict_cnt
  );
endinterface

// File: rtl/wbus_arbiter.sv
// Round-robin WBUS arbiter with bus locking, registered bus driver and a
// saturating request-collision counter.
module wbus_arbiter #(
  parameter int unsigned N_SRC = 9,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic  CLK,
  input  logic  nCLR,
  wbus_if.slave wb
);
  localparam int unsigned IW = $clog2(N_SRC);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [DW-1:0]    bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;

  logic [DW-1:0]    src_arr [N_SRC];
  logic [CW-1:0]    cand;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic             lock_hold;
  logic             multi_req;

  // Unflatten the source data bus.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src_arr[i] = wb.src_data[i*DW +: DW];
  end

  // Round-robin scan starting at ptr, wrapping at N_SRC.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = CW'(ptr_q) + CW'(k);
      if (cand >= CW'(N_SRC)) cand = cand - CW'(N_SRC);
      if (!win_found && wb.req[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Locked owner keeps the bus only while both its req and lock stay high.
  assign lock_hold = (state_q == S_LOCKED) && wb.req[owner_q] && wb.lock[owner_q];
  assign multi_req = |(wb.req & (wb.req - N_SRC'(1)));

  // State register.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: stay locked, or follow the new winner's lock bit.
  always_comb begin
    state_d = S_IDLE;
    if (lock_hold)      state_d = S_LOCKED;
    else if (win_found) state_d = wb.lock[win_idx] ? S_LOCKED : S_GRANT;
  end

  // Output/datapath next values; IDLE and GRANT arbitrate identically.
  always_comb begin
    grant_d = '0;
    bus_d   = bus_q;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (lock_hold) begin
      grant_d = grant_q;
      bus_d   = src_arr[owner_q];
      valid_d = 1'b1;
    end else if (win_found) begin
      grant_d = N_SRC'(1) << win_idx;
      bus_d   = src_arr[win_idx];
      valid_d = 1'b1;
      owner_d = win_idx;
      ptr_d   = (win_idx == IW'(N_SRC - 1)) ? '0 : win_idx + IW'(1);
    end
    if (wb.clr_stat)                              cnt_d = '0;
    else if (!lock_hold && multi_req && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      grant_q <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      grant_q <= grant_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign wb.grant        = grant_q;
  assign wb.bus_out      = bus_q;
  assign wb.bus_valid    = valid_q;
  assign wb.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wbus_arbiter.sv
// Directed bench for the WBUS round-robin arbiter.
module tb_wbus_arbiter;
  logic CLK = 1'b0;
  logic nCLR;
  int   checks = 0;
  int   errors = 0;

  wbus_if #(.N_SRC(9), .DW(16), .CNT_W(8)) wb ();

  wbus_arbiter #(.N_SRC(9), .DW(16), .CNT_W(8)) dut (
    .CLK  (CLK),
    .nCLR (nCLR),
    .wb   (wb)
  );

  always #5 CLK = ~CLK;

  // Grant must never be multi-hot.
  always @(negedge CLK)
    if (nCLR) assert ($onehot0(wb.grant)) else $error("FAIL onehot grant=%h", wb.grant);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_src(input int i, input logic [15:0] v);
    wb.src_data[i*16 +: 16] = v;
  endtask

  task automatic do_reset();
    nCLR = 1'b0;
    wb.req = '0; wb.lock = '0; wb.clr_stat = 1'b0;
    for (int i = 0; i < 9; i++) set_src(i, 16'hA000 + 16'(i));
    tick();
    nCLR = 1'b1;
  endtask

  task automatic test_reset();
    nCLR = 1'b0;
    wb.req = 9'h1FF; wb.lock = '0; wb.clr_stat = 1'b0;
    for (int i = 0; i < 9; i++) set_src(i, 16'hA000 + 16'(i));
    tick(); tick();
    checks++; if (wb.grant !== 9'h000) begin errors++; $display("FAIL reset_grant got=%h exp=000", wb.grant); end
    checks++; if (wb.bus_out !== 16'h0000) begin errors++; $display("FAIL reset_bus got=%h exp=0000", wb.bus_out); end
    checks++; if (wb.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", wb.bus_valid); end
    checks++; if (wb.conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", wb.conflict_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 16'h1234);
    wb.req = 9'h001;
    tick();
    checks++; if (wb.grant !== 9'h001) begin errors++; $display("FAIL single_grant got=%h exp=001", wb.grant); end
    checks++; if (wb.bus_out !== 16'h1234) begin errors++; $display("FAIL single_bus got=%h exp=1234", wb.bus_out); end
    checks++; if (wb.bus_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", wb.bus_valid); end
    wb.req = 9'h000;
    tick();
    checks++; if (wb.grant !== 9'h000) begin errors++; $display("FAIL idle_grant got=%h exp=000", wb.grant); end
    checks++; if (wb.bus_out !== 16'h1234) begin errors++; $display("FAIL idle_bus_hold got=%h exp=1234", wb.bus_out); end
    checks++; if (wb.bus_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", wb.bus_valid); end
  endtask

  task automatic test_round_robin();
    logic [8:0]  exp_g [4];
    logic [15:0] exp_b [4];
    exp_g[0] = 9'h001; exp_g[1] = 9'h004; exp_g[2] = 9'h001; exp_g[3] = 9'h004;
    exp_b[0] = 16'hA000; exp_b[1] = 16'hA002; exp_b[2] = 16'hA000; exp_b[3] = 16'hA002;
    do_reset();
    wb.req = 9'h005;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wb.grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d] got=%h exp=%h", i, wb.grant, exp_g[i]); end
      checks++; if (wb.bus_out !== exp_b[i]) begin errors++; $display("FAIL rr_bus[%0d] got=%h exp=%h", i, wb.bus_out, exp_b[i]); end
    end
    checks++; if (wb.conflict_cnt !== 8'd4) begin errors++; $display("FAIL rr_cnt got=%0d exp=4", wb.conflict_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    wb.req = 9'h080;
    tick();
    checks++; if (wb.grant !== 9'h080) begin errors++; $display("FAIL wrap_setup got=%h exp=080", wb.grant); end
    wb.req = 9'h000;
    tick();
    wb.req = 9'h101;
    tick();
    checks++; if (wb.grant !== 9'h100) begin errors++; $display("FAIL wrap_first got=%h exp=100", wb.grant); end
    checks++; if (wb.bus_out !== 16'hA008) begin errors++; $display("FAIL wrap_bus got=%h exp=A008", wb.bus_out); end
    tick();
    checks++; if (wb.grant !== 9'h001) begin errors++; $display("FAIL wrap_second got=%h exp=001", wb.grant); end
  endtask

  task automatic test_lock();
    do_reset();
    wb.req  = 9'h022;
    wb.lock = 9'h002;
    for (int i = 0; i < 5; i++) begin
      set_src(1, 16'hB000 + 16'(i));
      tick();
      checks++; if (wb.grant !== 9'h002) begin errors++; $display("FAIL lock_grant[%0d] got=%h exp=002", i, wb.grant); end
      checks++; if (wb.bus_out !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL lock_bus[%0d] got=%h exp=%h", i, wb.bus_out, 16'hB000 + 16'(i)); end
      checks++; if (wb.conflict_cnt !== 8'd1) begin errors++; $display("FAIL lock_cnt[%0d] got=%0d exp=1", i, wb.conflict_cnt); end
    end
    wb.lock = 9'h000;
    tick();
    checks++; if (wb.grant !== 9'h020) begin errors++; $display("FAIL release_grant got=%h exp=020", wb.grant); end
    checks++; if (wb.bus_out !== 16'hA005) begin errors++; $display("FAIL release_bus got=%h exp=A005", wb.bus_out); end
    checks++; if (wb.conflict_cnt !== 8'd2) begin errors++; $display("FAIL release_cnt got=%0d exp=2", wb.conflict_cnt); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    wb.req = 9'h001; wb.lock = 9'h001;
    tick();
    checks++; if (wb.grant !== 9'h001) begin errors++; $display("FAIL midlock_setup got=%h exp=001", wb.grant); end
    nCLR = 1'b0;
    #1;
    checks++; if (wb.grant !== 9'h000) begin errors++; $display("FAIL midlock_async_grant got=%h exp=000", wb.grant); end
    checks++; if (wb.bus_out !== 16'h0000) begin errors++; $display("FAIL midlock_async_bus got=%h exp=0000", wb.bus_out); end
    wb.req = 9'h002;
    tick();
    nCLR = 1'b1;
    tick();
    checks++; if (wb.grant !== 9'h002) begin errors++; $display("FAIL midlock_no_resume got=%h exp=002", wb.grant); end
  endtask

  task automatic test_saturation();
    do_reset();
    wb.req = 9'h003;
    repeat (300) tick();
    checks++; if (wb.conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", wb.conflict_cnt); end
    wb.clr_stat = 1'b1;
    tick();
    checks++; if (wb.conflict_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", wb.conflict_cnt); end
    wb.clr_stat = 1'b0;
    tick();
    checks++; if (wb.conflict_cnt !== 8'd1) begin errors++; $display("FAIL post_clr_cnt got=%0d exp=1", wb.conflict_cnt); end
  endtask

  initial begin
    wb.req = '0; wb.lock = '0; wb.clr_stat = 1'b0; wb.src_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_lock();
    test_reset_mid_lock();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
